// File: rtl/ame_num_denormal.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ame_num_denormal
//
// Restores a normalised signed integer to full scale. The magnitude of the
// input is shifted left by comp_shift_i, one binary-weighted stage per clock,
// and the sign is re-applied at the end. If the full-scale value does not fit
// in W signed bits, the result either saturates (SAT_EN=1) or wraps (SAT_EN=0),
// and comp_ovf_o is raised.
//
// Handshake: comp_init_i is a level request. The operands are captured on the
// first edge that sees it high. comp_done_o rises S+1 edges after that first
// edge, counting that edge, and stays high while comp_init_i stays high.
// Dropping comp_init_i before done aborts the operation. Whenever a result is
// not being presented, comp_data_o passes comp_data_i straight through.
//
// Ports
//   clk_i         in   clock, rising edge
//   rst_n_i       in   asynchronous active-low reset
//   comp_init_i   in   level request, hold high until done is seen
//   comp_done_o   out  result valid, held while comp_init_i is high
//   comp_ovf_o    out  overflow flag for the presented result
//   comp_shift_i  in   left-shift amount, 0..W-1
//   comp_data_i   in   signed two's-complement operand
//   comp_data_o   out  signed result, or pass-through of comp_data_i
// -----------------------------------------------------------------------------
module ame_num_denormal #(
  parameter int COMP_DATA_BITS = 64,
  parameter bit SAT_EN         = 1'b1
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               comp_init_i,
  output logic                               comp_done_o,
  output logic                               comp_ovf_o,
  input  logic [$clog2(COMP_DATA_BITS)-1:0]  comp_shift_i,
  input  logic [COMP_DATA_BITS-1:0]          comp_data_i,
  output logic [COMP_DATA_BITS-1:0]          comp_data_o
);

  localparam int W  = COMP_DATA_BITS;
  localparam int S  = $clog2(W);   // number of shift stages
  localparam int SW = $clog2(S);   // width of the stage counter

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Operand and progress registers.
  logic [W-1:0]  mag_reg;     // unsigned magnitude being shifted
  logic          sign_reg;    // sign of the captured operand
  logic [S-1:0]  shift_reg;   // captured shift amount, one bit per stage
  logic          ovf_reg;     // sticky: some set bit has been shifted out
  logic [SW-1:0] stage_reg;   // stage k currently being applied

  // Magnitude of the live input. The most negative value maps to 2^(W-1),
  // which is representable as an unsigned W-bit number.
  logic [W-1:0] in_mag;
  assign in_mag = comp_data_i[W-1] ? (~comp_data_i + W'(1)) : comp_data_i;

  // ---------------------------------------------------------------------------
  // Per-stage shift results. Stage gi shifts by 2^gi. The bits that would fall
  // off the top are reduced to a single flag so the overflow can be tracked
  // without widening the datapath.
  // ---------------------------------------------------------------------------
  logic [W-1:0] stage_mag [S];
  logic [S-1:0] stage_out;

  genvar gi;
  generate
    for (gi = 0; gi < S; gi++) begin : g_stage
      localparam int AMT = 1 << gi;
      assign stage_mag[gi] = mag_reg << AMT;
      assign stage_out[gi] = |mag_reg[W-1 -: AMT];
    end
  endgenerate

  // Select the stage addressed by the counter.
  logic [W-1:0] sel_mag;
  logic         sel_out;
  logic         sel_en;
  logic         last_stage;

  always_comb begin
    sel_mag = mag_reg;
    sel_out = 1'b0;
    sel_en  = 1'b0;
    for (int i = 0; i < S; i++) begin
      if (stage_reg == SW'(i)) begin
        sel_mag = stage_mag[i];
        sel_out = stage_out[i];
        sel_en  = shift_reg[i];
      end
    end
  end

  assign last_stage = (stage_reg == SW'(S - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (comp_init_i) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A dropped request abandons the operation without presenting a result.
        if (!comp_init_i) begin
          state_next = ST_IDLE;
        end else if (last_stage) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!comp_init_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mag_reg   <= '0;
      sign_reg  <= 1'b0;
      shift_reg <= '0;
      ovf_reg   <= 1'b0;
      stage_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (comp_init_i) begin
            mag_reg   <= in_mag;
            sign_reg  <= comp_data_i[W-1];
            shift_reg <= comp_shift_i;
            ovf_reg   <= 1'b0;
            stage_reg <= '0;
          end
        end
        ST_SHIFT: begin
          if (comp_init_i) begin
            if (sel_en) begin
              mag_reg <= sel_mag;
              ovf_reg <= ovf_reg | sel_out;
            end
            stage_reg <= stage_reg + SW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result formation. A positive result overflows once the top bit is set; a
  // negative one may reach exactly 2^(W-1) and still be representable.
  // ---------------------------------------------------------------------------
  logic         ovf_final;
  logic [W-1:0] signed_res;
  logic [W-1:0] sat_val;

  assign ovf_final  = ovf_reg
                    | (~sign_reg & mag_reg[W-1])
                    | (sign_reg & mag_reg[W-1] & (|mag_reg[W-2:0]));
  assign signed_res = sign_reg ? (~mag_reg + W'(1)) : mag_reg;
  assign sat_val    = sign_reg ? MIN_NEG : MAX_POS;

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    comp_done_o = 1'b0;
    comp_ovf_o  = 1'b0;
    comp_data_o = comp_data_i;
    if (state_reg == ST_DONE) begin
      comp_done_o = 1'b1;
      comp_ovf_o  = ovf_final;
      if (SAT_EN && ovf_final) begin
        comp_data_o = sat_val;
      end else begin
        comp_data_o = signed_res;
      end
    end
  end

endmodule

// File: tb/tb_ame_num_denormal.sv
`timescale 1ns/1ps
module tb_ame_num_denormal;

  localparam int W = 64;
  localparam int S = 6;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         comp_init_i;
  logic [S-1:0] comp_shift_i;
  logic [W-1:0] comp_data_i;

  logic         done_sat, ovf_sat, done_wrap, ovf_wrap;
  logic [W-1:0] data_sat, data_wrap;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] d_sat;
    logic [W-1:0] d_wrap;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk_i = ~clk_i;

  ame_num_denormal #(.COMP_DATA_BITS(W), .SAT_EN(1'b1)) dut_sat (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .comp_init_i (comp_init_i),
    .comp_done_o (done_sat),
    .comp_ovf_o  (ovf_sat),
    .comp_shift_i(comp_shift_i),
    .comp_data_i (comp_data_i),
    .comp_data_o (data_sat)
  );

  ame_num_denormal #(.COMP_DATA_BITS(W), .SAT_EN(1'b0)) dut_wrap (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .comp_init_i (comp_init_i),
    .comp_done_o (done_wrap),
    .comp_ovf_o  (ovf_wrap),
    .comp_shift_i(comp_shift_i),
    .comp_data_i (comp_data_i),
    .comp_data_o (data_wrap)
  );

  // Reference: exact full-scale value in 128 bits, then range check.
  function automatic exp_t model(input logic [W-1:0] d, input logic [S-1:0] sh);
    exp_t         e;
    logic         sign;
    logic [127:0] mag, full, neg;
    logic [W-1:0] wrapv;
    sign  = d[W-1];
    mag   = sign ? ((128'd1 << 64) - {64'd0, d}) : {64'd0, d};
    full  = mag << sh;
    e.ovf = sign ? (full > (128'd1 << 63)) : (full >= (128'd1 << 63));
    neg   = 128'd0 - full;
    wrapv = sign ? neg[W-1:0] : full[W-1:0];
    e.d_wrap = wrapv;
    e.d_sat  = e.ovf ? (sign ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF) : wrapv;
    return e;
  endfunction

  // One request: drive, push expectation, wait for done, pop and compare,
  // optionally hold init in DONE, then release and check the return to IDLE.
  task automatic run_op(input logic [W-1:0] d, input logic [S-1:0] sh, input int hold,
                        input string tag,
                        output logic [W-1:0] o_sat, output logic [W-1:0] o_wrap,
                        output logic o_ovf_sat, output logic o_ovf_wrap);
    exp_t e;
    int   lat;
    @(negedge clk_i);
    comp_data_i  = d;
    comp_shift_i = sh;
    comp_init_i  = 1'b1;
    exp_q.push_back(model(d, sh));
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_i); #1;
      if (c == 1) begin
        // operands are captured at start; later changes must be ignored
        comp_data_i  = {$urandom, $urandom};
        comp_shift_i = S'($urandom);
        #1;
      end
      if (done_sat || done_wrap) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL %s latency: got %0d want 7", tag, lat);
    end
    checks++;
    if ({done_sat, done_wrap} !== 2'b11) begin
      errors++;
      $display("FAIL %s done_both: got %b want 11", tag, {done_sat, done_wrap});
    end
    e = exp_q.pop_front();
    o_sat = data_sat; o_wrap = data_wrap; o_ovf_sat = ovf_sat; o_ovf_wrap = ovf_wrap;
    checks++;
    if (data_sat !== e.d_sat) begin
      errors++;
      $display("FAIL %s data_sat: got %h want %h", tag, data_sat, e.d_sat);
    end
    checks++;
    if (data_wrap !== e.d_wrap) begin
      errors++;
      $display("FAIL %s data_wrap: got %h want %h", tag, data_wrap, e.d_wrap);
    end
    checks++;
    if ({ovf_sat, ovf_wrap} !== {e.ovf, e.ovf}) begin
      errors++;
      $display("FAIL %s ovf: got %b want %b", tag, {ovf_sat, ovf_wrap}, {e.ovf, e.ovf});
    end
    $display("op %s data=%h shift=%0d sat=%h wrap=%h ovf=%b lat=%0d",
             tag, d, sh, data_sat, data_wrap, ovf_sat, lat);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_i); #1;
      checks++;
      if ({done_sat, data_sat} !== {1'b1, e.d_sat}) begin
        errors++;
        $display("FAIL %s hold: got done=%b data=%h want done=1 data=%h",
                 tag, done_sat, data_sat, e.d_sat);
      end
    end
    comp_init_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if ({done_sat, done_wrap, ovf_sat, ovf_wrap} !== 4'b0000 || data_sat !== comp_data_i) begin
      errors++;
      $display("FAIL %s release: got done=%b ovf=%b data=%h want 0 0 %h",
               tag, done_sat, ovf_sat, data_sat, comp_data_i);
    end
  endtask

  task automatic test_reset();
    rst_n_i      = 1'b0;
    comp_init_i  = 1'b0;
    comp_shift_i = '0;
    comp_data_i  = 64'h1234_5678_9ABC_DEF0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({done_sat, ovf_sat, done_wrap, ovf_wrap} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000", {done_sat, ovf_sat, done_wrap, ovf_wrap});
    end
    checks++;
    if (data_sat !== 64'h1234_5678_9ABC_DEF0 || data_wrap !== 64'h1234_5678_9ABC_DEF0) begin
      errors++;
      $display("FAIL reset_passthru: got %h/%h want 123456789abcdef0", data_sat, data_wrap);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    $display("op reset done");
  endtask

  task automatic test_basic();
    logic [W-1:0] s, w;
    logic os, ow;
    run_op(64'd5, 6'd3, 0, "basic_5s3", s, w, os, ow);
    checks++;
    if ({s, os} !== {64'd40, 1'b0}) begin
      errors++;
      $display("FAIL basic_5s3_lit: got %h ovf=%b want 28 ovf=0", s, os);
    end
    run_op(64'hFFFF_FFFF_FFFF_FFFD, 6'd4, 0, "basic_m3s4", s, w, os, ow);
    checks++;
    if ({s, os} !== {64'hFFFF_FFFF_FFFF_FFD0, 1'b0}) begin
      errors++;
      $display("FAIL basic_m3s4_lit: got %h ovf=%b want ffffffffffffffd0 ovf=0", s, os);
    end
  endtask

  task automatic test_saturate();
    logic [W-1:0] s, w;
    logic os, ow;
    run_op(64'h4000_0000_0000_0000, 6'd1, 0, "sat_pos", s, w, os, ow);
    checks++;
    if ({s, os} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b1}) begin
      errors++;
      $display("FAIL sat_pos_lit: got %h ovf=%b want 7fffffffffffffff ovf=1", s, os);
    end
    run_op(64'hC000_0000_0000_0000, 6'd1, 0, "sat_neg", s, w, os, ow);
    checks++;
    if ({s, os} !== {64'h8000_0000_0000_0000, 1'b0}) begin
      errors++;
      $display("FAIL sat_neg_lit: got %h ovf=%b want 8000000000000000 ovf=0", s, os);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] s, w;
    logic os, ow;
    run_op(64'd3, 6'd63, 0, "wrap_3s63", s, w, os, ow);
    checks++;
    if ({w, ow} !== {64'h8000_0000_0000_0000, 1'b1}) begin
      errors++;
      $display("FAIL wrap_3s63_lit: got %h ovf=%b want 8000000000000000 ovf=1", w, ow);
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] s, w;
    logic os, ow;
    run_op(64'd0, 6'd63, 0, "zero_s63", s, w, os, ow);
    checks++;
    if ({s, os} !== {64'd0, 1'b0}) begin
      errors++;
      $display("FAIL zero_s63_lit: got %h ovf=%b want 0 ovf=0", s, os);
    end
    run_op(64'h8000_0000_0000_0000, 6'd0, 0, "minneg_s0", s, w, os, ow);
    checks++;
    if ({w, os} !== {64'h8000_0000_0000_0000, 1'b0}) begin
      errors++;
      $display("FAIL minneg_s0_lit: got %h ovf=%b want 8000000000000000 ovf=0", w, os);
    end
    run_op(64'h8000_0000_0000_0000, 6'd1, 0, "minneg_s1", s, w, os, ow);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 6'd0, 0, "maxpos_s0", s, w, os, ow);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 0, "m1_s63", s, w, os, ow);
    run_op(64'h0000_0000_0000_0001, 6'd63, 0, "p1_s63", s, w, os, ow);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s, w;
    logic os, ow;
    run_op(64'h0000_0000_0000_00FF, 6'd8, 3, "hold_a", s, w, os, ow);
    run_op(64'hFFFF_FFFF_FFFF_FF00, 6'd2, 2, "hold_b", s, w, os, ow);
  endtask

  task automatic test_abort();
    logic [W-1:0] s, w;
    logic os, ow;
    @(negedge clk_i);
    comp_data_i  = 64'd77;
    comp_shift_i = 6'd5;
    comp_init_i  = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    comp_init_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_i); #1;
      comp_data_i = {$urandom, $urandom};
      #1;
      checks++;
      if ({done_sat, done_wrap} !== 2'b00 || data_sat !== comp_data_i) begin
        errors++;
        $display("FAIL abort_idle: got done=%b data=%h want 0 %h", done_sat, data_sat, comp_data_i);
      end
    end
    $display("op abort done");
    run_op(64'd1, 6'd0, 0, "after_abort", s, w, os, ow);
    checks++;
    if ({s, os} !== {64'd1, 1'b0}) begin
      errors++;
      $display("FAIL after_abort_lit: got %h ovf=%b want 1 ovf=0", s, os);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s, w;
    logic os, ow;
    @(negedge clk_i);
    comp_data_i  = 64'h4000_0000_0000_0000;
    comp_shift_i = 6'd1;
    comp_init_i  = 1'b1;
    repeat (3) @(posedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({done_sat, ovf_sat, done_wrap, ovf_wrap} !== 4'b0000 || data_sat !== comp_data_i) begin
      errors++;
      $display("FAIL rst_mid: got flags=%b data=%h want 0000 %h",
               {done_sat, ovf_sat, done_wrap, ovf_wrap}, data_sat, comp_data_i);
    end
    comp_init_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      comp_data_i = {$urandom, $urandom};
      #1;
      checks++;
      if (data_sat !== comp_data_i || data_wrap !== comp_data_i) begin
        errors++;
        $display("FAIL rst_track: got %h/%h want %h", data_sat, data_wrap, comp_data_i);
      end
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    $display("op reset_mid done");
    run_op(64'd9, 6'd2, 0, "after_reset", s, w, os, ow);
  endtask

  task automatic test_random();
    logic [W-1:0] s, w, d;
    logic os, ow;
    for (int n = 0; n < 2000; n++) begin
      d = {$urandom, $urandom};
      d = $signed(d) >>> $urandom_range(0, 63);
      run_op(d, S'($urandom), 0, "rand", s, w, os, ow);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_wrap();
    test_boundary();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
